// File: rtl/sram_access_controller.sv
// Single-port word SRAM behind an enable/done 4-phase handshake with programmable wait states.
// Optional per-byte write lanes when SRAM_BYTE_WRITE_EN is defined (adds byteEnable port).
module sram_access_controller #(
   parameter int ADDR_WIDTH  = 15,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 32768,
   parameter int WAIT_STATES = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    readWrite,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH-1:0]   dataIn,
`ifdef SRAM_BYTE_WRITE_EN
   input  logic [DATA_WIDTH/8-1:0] byteEnable,
`endif
   output logic [DATA_WIDTH-1:0]   dataOut,
   output logic                    done,
   output logic                    busy,
   output logic                    error
);

   localparam int LANES = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;

   state_t                  state_q, state_d;
   logic [2:0]              cnt_q, cnt_d;
   logic                    rw_q, rw_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [DATA_WIDTH-1:0]   dout_q, dout_d;
   logic                    done_q, done_d;
   logic                    busy_q, busy_d;
   logic                    err_q, err_d;
   logic                    mem_we;
   logic                    in_range;
   logic [IDX_W-1:0]        idx;
   logic [LANES-1:0]        lane_en;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef SRAM_BYTE_WRITE_EN
   logic [LANES-1:0]        be_q, be_d;
   assign lane_en = be_q;
`else
   assign lane_en = '1;
`endif

   assign in_range = (32'(addr_q) < 32'(DEPTH));
   assign idx      = addr_q[IDX_W-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      data_d  = data_q;
      dout_d  = dout_q;
      done_d  = done_q;
      err_d   = err_q;
      mem_we  = 1'b0;
`ifdef SRAM_BYTE_WRITE_EN
      be_d    = be_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (enable) begin
               rw_d    = readWrite;
               addr_d  = address;
               data_d  = dataIn;
`ifdef SRAM_BYTE_WRITE_EN
               be_d    = byteEnable;
`endif
               cnt_d   = 3'(WAIT_STATES);
               state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            // <=1 rather than ==1 so a stray zero count can never stall here
            if (cnt_q <= 3'd1) state_d = S_ACCESS;
         end
         S_ACCESS: begin
            done_d  = 1'b1;
            state_d = S_HOLD;
            if (!in_range)  err_d  = 1'b1;
            else if (rw_q)  mem_we = 1'b1;
            else            dout_d = mem[idx];
         end
         S_HOLD: begin
            if (!enable) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

`ifdef SRAM_BYTE_WRITE_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) be_q <= '0;
      else        be_q <= be_d;
   end
`endif

   // Array is never reset; a pending write dies with the FSM going to IDLE.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) mem[idx][8*i +: 8] <= data_q[8*i +: 8];
         end
      end
   end

   assign dataOut = dout_q;
   assign done    = done_q;
   assign busy    = busy_q;
   assign error   = err_q;

endmodule
